led_pattern_gen: RTL

- Parametrised, multi-channel successor to the single fixed-rate LED blinker.
- Drives CHANNELS LED outputs from a shared tick prescaler. Each channel has its own mode: off, on, blink with programmable half-period, or PWM with programmable duty.
- Channels are configured one at a time through a register-write port. A sync strobe phase-aligns all channels.
- Sits between board/top-level control logic and the LED pins.

---
 rtl/led_pattern_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared tick prescaler drives per-channel
// off / on / blink / pwm state machines that are configured one channel at a time.
module led_pattern_gen #(
  parameter  int CHANNELS = 4,
  parameter  int PRESCALE = 1,
  parameter  int CNT_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_val,
  input  logic                sync,
  output logic                cfg_err,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  // PWM counter stops one short of all-ones so that val = all-ones means always on.
  localparam logic [CNT_W-1:0] PWM_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  logic [PRE_W-1:0] pre_r;
  logic             tick_r;
  logic             cfg_err_r;
  mode_t            mode_r  [CHANNELS];
  logic [CNT_W-1:0] val_r   [CHANNELS];
  logic [CNT_W-1:0] cnt_r   [CHANNELS];
  logic             phase_r [CHANNELS];

  logic                valid_wr_s;
  logic                invalid_wr_s;
  logic [CNT_W-1:0]    blink_last_s [CHANNELS];
  logic [CHANNELS-1:0] led_s;

  // Classify the current write as targeting an existing or a missing channel.
  always_comb begin
    valid_wr_s   = 1'b0;
    invalid_wr_s = 1'b0;
    if (cfg_we) begin
      if ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(CHANNELS)) begin
        valid_wr_s = 1'b1;
      end else begin
        invalid_wr_s = 1'b1;
      end
    end else begin
      valid_wr_s   = 1'b0;
      invalid_wr_s = 1'b0;
    end
  end

  // Last count value of a blink half-period; val = 0 behaves like val = 1.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (val_r[i] == {CNT_W{1'b0}}) begin
        blink_last_s[i] = {CNT_W{1'b0}};
      end else begin
        blink_last_s[i] = val_r[i] - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Shared prescaler, tick pulse and invalid-write error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r     <= {PRE_W{1'b0}};
      tick_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= invalid_wr_s;
      if (sync) begin
        pre_r  <= {PRE_W{1'b0}};
        tick_r <= (PRESCALE == 1);
      end else begin
        tick_r <= (pre_r == PRE_LAST);
        if (pre_r == PRE_LAST) begin
          pre_r <= {PRE_W{1'b0}};
        end else begin
          pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Per-channel state: a write to the channel beats sync, which beats a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_r[i]  <= MODE_OFF;
        val_r[i]   <= {CNT_W{1'b0}};
        cnt_r[i]   <= {CNT_W{1'b0}};
        phase_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (valid_wr_s && ({{(32-CH_W){1'b0}}, cfg_ch} == 32'(i))) begin
          mode_r[i]  <= mode_t'(cfg_mode);
          val_r[i]   <= cfg_val;
          cnt_r[i]   <= {CNT_W{1'b0}};
          phase_r[i] <= 1'b1;
        end else if (sync) begin
          cnt_r[i]   <= {CNT_W{1'b0}};
          phase_r[i] <= 1'b1;
        end else if (tick_r) begin
          case (mode_r[i])
            MODE_OFF: begin
              cnt_r[i]   <= {CNT_W{1'b0}};
              phase_r[i] <= 1'b0;
            end
            MODE_ON: begin
              cnt_r[i]   <= cnt_r[i];
              phase_r[i] <= phase_r[i];
            end
            MODE_BLINK: begin
              if (cnt_r[i] == blink_last_s[i]) begin
                cnt_r[i]   <= {CNT_W{1'b0}};
                phase_r[i] <= ~phase_r[i];
              end else begin
                cnt_r[i]   <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
            MODE_PWM: begin
              if (cnt_r[i] >= PWM_LAST) begin
                cnt_r[i] <= {CNT_W{1'b0}};
              end else begin
                cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
            default: begin
              cnt_r[i]   <= {CNT_W{1'b0}};
              phase_r[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // LED drive decoded from registered channel state only.
  always_comb begin
    led_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode_r[i])
        MODE_OFF:   led_s[i] = 1'b0;
        MODE_ON:    led_s[i] = 1'b1;
        MODE_BLINK: led_s[i] = phase_r[i];
        MODE_PWM:   led_s[i] = (cnt_r[i] < val_r[i]);
        default:    led_s[i] = 1'b0;
      endcase
    end
  end

  assign led     = led_s;
  assign tick    = tick_r;
  assign cfg_err = cfg_err_r;

endmodule
